// File: rtl/can_bit_stuffer_pkg.sv
// Shared CAN constants and the bit-stuffer state encoding.
package can_bit_stuffer_pkg;

  localparam int   CAN_STUFF_LIMIT = 5;
  localparam logic CAN_RECESSIVE   = 1'b1;
  localparam logic CAN_DOMINANT    = 1'b0;

  typedef enum logic [1:0] {
    STUFF_NORMAL = 2'd0,
    STUFF_INSERT = 2'd1,
    STUFF_LOST   = 2'd2
  } type_stuffer_state_e;

endpackage

// File: rtl/can_bit_stuffer_if.sv
// Transmitter/bus-side signal bundle for the CAN bit stuffer.
interface can_bit_stuffer_if
  import can_bit_stuffer_pkg::*;
#(
  parameter int CNT_W = 3
);
  // Handshake: sample_point is a one-cycle strobe per bit time; the stuffer
  // answers in the same cycle with tx_advance, and the transmitter moves to
  // its next bit only on cycles where both are high.
  logic                sample_point;
  logic                tx_bit_in;
  logic                stuff_en;
  logic                arbitration_active;
  logic                rx_bit;
  logic                tx_advance;
  logic                tx_bit_out;
  logic                stuff_bit_active;
  logic                arb_lost;
  logic                bit_error;
  logic [CNT_W-1:0]    run_count;
  type_stuffer_state_e state;

  modport master (
    output sample_point, tx_bit_in, stuff_en, arbitration_active, rx_bit,
    input  tx_advance, tx_bit_out, stuff_bit_active, arb_lost, bit_error,
           run_count, state
  );

  modport slave (
    input  sample_point, tx_bit_in, stuff_en, arbitration_active, rx_bit,
    output tx_advance, tx_bit_out, stuff_bit_active, arb_lost, bit_error,
           run_count, state
  );

endinterface

// File: rtl/can_bit_stuffer.sv
// CAN TX bit stuffer: inserts stuff bits, stalls the transmitter during them,
// and checks bus readback for arbitration loss and bit errors.
module can_bit_stuffer
  import can_bit_stuffer_pkg::*;
#(
  parameter int STUFF_LIMIT = CAN_STUFF_LIMIT,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  can_bit_stuffer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STUFF_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  type_stuffer_state_e state_q, state_d;
  logic             tx_q, tx_d;
  logic             stuff_act_q, stuff_act_d;
  logic             arb_lost_q, arb_lost_d;
  logic             bit_err_q, bit_err_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             drv_se_q, drv_se_d;
  logic             drv_arb_q, drv_arb_d;
  logic             arb_loss;
  logic             mismatch;
  logic [CNT_W-1:0] run_inc;

  // Readback checks look at the bit driven during the bit time now ending.
  assign arb_loss = drv_arb_q & (tx_q == CAN_RECESSIVE) & (bus.rx_bit == CAN_DOMINANT);
  assign mismatch = drv_se_q & (bus.rx_bit != tx_q);
  assign run_inc  = (run_q >= LIMIT_C) ? LIMIT_C : run_q + ONE_C;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    stuff_act_d = stuff_act_q;
    run_d       = run_q;
    drv_se_d    = drv_se_q;
    drv_arb_d   = drv_arb_q;
    arb_lost_d  = 1'b0;
    bit_err_d   = 1'b0;

    if (bus.sample_point) begin
      arb_lost_d = arb_loss;
      bit_err_d  = ~arb_loss & mismatch;

      if (state_q == STUFF_LOST || arb_loss) begin
        // Loser goes recessive and unchecked until the stuffing region ends.
        tx_d        = CAN_RECESSIVE;
        stuff_act_d = 1'b0;
        run_d       = '0;
        drv_se_d    = 1'b0;
        drv_arb_d   = 1'b0;
        state_d     = (state_q == STUFF_LOST && !bus.stuff_en) ? STUFF_NORMAL : STUFF_LOST;
      end else if (state_q == STUFF_INSERT) begin
        tx_d        = ~tx_q;
        stuff_act_d = 1'b1;
        run_d       = ONE_C;
        state_d     = STUFF_NORMAL;
      end else begin
        tx_d        = bus.tx_bit_in;
        stuff_act_d = 1'b0;
        drv_se_d    = bus.stuff_en;
        drv_arb_d   = bus.arbitration_active;
        if (!bus.stuff_en) begin
          run_d = '0;
        end else if (bus.tx_bit_in == tx_q) begin
          run_d = run_inc;
        end else begin
          run_d = ONE_C;
        end
        if (bus.stuff_en && run_d == LIMIT_C) begin
          state_d = STUFF_INSERT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= STUFF_NORMAL;
      tx_q        <= CAN_RECESSIVE;
      stuff_act_q <= 1'b0;
      arb_lost_q  <= 1'b0;
      bit_err_q   <= 1'b0;
      run_q       <= '0;
      drv_se_q    <= 1'b0;
      drv_arb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      stuff_act_q <= stuff_act_d;
      arb_lost_q  <= arb_lost_d;
      bit_err_q   <= bit_err_d;
      run_q       <= run_d;
      drv_se_q    <= drv_se_d;
      drv_arb_q   <= drv_arb_d;
    end
  end

  // On a fresh loss the pending stuff bit is dropped, so the transmitter runs.
  assign bus.tx_advance       = bus.sample_point & ((state_q != STUFF_INSERT) | arb_loss);
  assign bus.tx_bit_out       = tx_q;
  assign bus.stuff_bit_active = stuff_act_q;
  assign bus.arb_lost         = arb_lost_q;
  assign bus.bit_error        = bit_err_q;
  assign bus.run_count        = run_q;
  assign bus.state            = state_q;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Directed self-checking bench for can_bit_stuffer.
module tb_can_bit_stuffer;
  import can_bit_stuffer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  logic       o_adv;
  logic       o_tx;
  logic       o_st;
  logic       o_arb;
  logic       o_err;
  logic [2:0] o_run;

  can_bit_stuffer_if #(.CNT_W(3)) bus ();

  can_bit_stuffer #(.STUFF_LIMIT(5), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bit time: present inputs, raise sample_point for exactly one edge.
  task automatic step(input logic b, input logic se, input logic arb,
                      input logic rx_frc, input logic rx_val);
    @(negedge clk);
    bus.tx_bit_in          = b;
    bus.stuff_en           = se;
    bus.arbitration_active = arb;
    bus.rx_bit             = rx_frc ? rx_val : bus.tx_bit_out;
    bus.sample_point       = 1'b1;
    #1;
    o_adv = bus.tx_advance;
    @(posedge clk);
    #1;
    bus.sample_point = 1'b0;
    o_tx  = bus.tx_bit_out;
    o_st  = bus.stuff_bit_active;
    o_arb = bus.arb_lost;
    o_err = bus.bit_error;
    o_run = bus.run_count;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n                  = 1'b0;
    bus.sample_point       = 1'b0;
    bus.tx_bit_in          = 1'b1;
    bus.stuff_en           = 1'b0;
    bus.arbitration_active = 1'b0;
    bus.rx_bit             = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++; if (bus.tx_bit_out !== 1'b1) $display("FAIL rst_tx got %b exp 1", bus.tx_bit_out); else n_pass++;
    n_total++; if (bus.stuff_bit_active !== 1'b0) $display("FAIL rst_stuff got %b exp 0", bus.stuff_bit_active); else n_pass++;
    n_total++; if (bus.arb_lost !== 1'b0) $display("FAIL rst_arb got %b exp 0", bus.arb_lost); else n_pass++;
    n_total++; if (bus.bit_error !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.bit_error); else n_pass++;
    n_total++; if (bus.run_count !== 3'd0) $display("FAIL rst_run got %0d exp 0", bus.run_count); else n_pass++;
    n_total++; if (bus.tx_advance !== 1'b0) $display("FAIL rst_adv got %b exp 0", bus.tx_advance); else n_pass++;
  endtask

  task automatic test_sof_id0();
    logic [11:0] e_tx;
    logic [11:0] e_adv;
    logic [2:0]  e_run [12];
    int idx;
    apply_reset();
    e_tx  = 12'b000001000001;
    e_adv = 12'b111110111110;
    e_run = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (o_adv) idx++;
      n_total++; if (o_tx !== e_tx[11-i]) $display("FAIL sof_tx[%0d] got %b exp %b", i, o_tx, e_tx[11-i]); else n_pass++;
      n_total++; if (o_st !== e_tx[11-i]) $display("FAIL sof_stuff[%0d] got %b exp %b", i, o_st, e_tx[11-i]); else n_pass++;
      n_total++; if (o_adv !== e_adv[11-i]) $display("FAIL sof_adv[%0d] got %b exp %b", i, o_adv, e_adv[11-i]); else n_pass++;
      n_total++; if (o_run !== e_run[i]) $display("FAIL sof_run[%0d] got %0d exp %0d", i, o_run, e_run[i]); else n_pass++;
      n_total++; if (o_err !== 1'b0) $display("FAIL sof_err[%0d] got %b exp 0", i, o_err); else n_pass++;
    end
    n_total++; if (idx != 10) $display("FAIL sof_advances got %0d exp 10", idx); else n_pass++;
  endtask

  task automatic test_alternating();
    logic b;
    apply_reset();
    b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++; if (o_tx !== b) $display("FAIL alt_tx[%0d] got %b exp %b", i, o_tx, b); else n_pass++;
      n_total++; if (o_run !== 3'd1) $display("FAIL alt_run[%0d] got %0d exp 1", i, o_run); else n_pass++;
      n_total++; if (o_adv !== 1'b1) $display("FAIL alt_adv[%0d] got %b exp 1", i, o_adv); else n_pass++;
      n_total++; if (o_st !== 1'b0) $display("FAIL alt_stuff[%0d] got %b exp 0", i, o_st); else n_pass++;
      b = ~b;
    end
  endtask

  task automatic test_crc_end();
    logic       fb  [9];
    logic       fse [9];
    logic [8:0] e_tx;
    logic [8:0] e_st;
    logic [8:0] e_adv;
    logic [2:0] e_run [9];
    int idx;
    apply_reset();
    fb    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fse   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e_tx  = 9'b011111011;
    e_st  = 9'b000000100;
    e_adv = 9'b111111011;
    e_run = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd0, 3'd0};
    idx = 0;
    for (int i = 0; i < 9; i++) begin
      // ACK slot (idx 7) reads back dominant from the receivers.
      step(fb[idx], fse[idx], 1'b0, (idx == 7), 1'b0);
      if (o_adv) idx++;
      n_total++; if (o_tx !== e_tx[8-i]) $display("FAIL crc_tx[%0d] got %b exp %b", i, o_tx, e_tx[8-i]); else n_pass++;
      n_total++; if (o_st !== e_st[8-i]) $display("FAIL crc_stuff[%0d] got %b exp %b", i, o_st, e_st[8-i]); else n_pass++;
      n_total++; if (o_adv !== e_adv[8-i]) $display("FAIL crc_adv[%0d] got %b exp %b", i, o_adv, e_adv[8-i]); else n_pass++;
      n_total++; if (o_run !== e_run[i]) $display("FAIL crc_run[%0d] got %0d exp %0d", i, o_run, e_run[i]); else n_pass++;
      n_total++; if (o_err !== 1'b0) $display("FAIL crc_err[%0d] got %b exp 0", i, o_err); else n_pass++;
    end
  endtask

  task automatic test_arb_lost();
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_total++; if (o_arb !== 1'b1) $display("FAIL arb_pulse got %b exp 1", o_arb); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL arb_err got %b exp 0", o_err); else n_pass++;
    n_total++; if (o_tx !== 1'b1) $display("FAIL arb_tx got %b exp 1", o_tx); else n_pass++;
    n_total++; if (o_adv !== 1'b1) $display("FAIL arb_adv got %b exp 1", o_adv); else n_pass++;
    n_total++; if (bus.state !== STUFF_LOST) $display("FAIL arb_state got %0d exp %0d", bus.state, STUFF_LOST); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.arb_lost !== 1'b0) $display("FAIL arb_clear got %b exp 0", bus.arb_lost); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      n_total++; if (o_tx !== 1'b1) $display("FAIL lost_tx[%0d] got %b exp 1", i, o_tx); else n_pass++;
      n_total++; if (o_st !== 1'b0) $display("FAIL lost_stuff[%0d] got %b exp 0", i, o_st); else n_pass++;
      n_total++; if (o_err !== 1'b0) $display("FAIL lost_err[%0d] got %b exp 0", i, o_err); else n_pass++;
      n_total++; if (o_arb !== 1'b0) $display("FAIL lost_arb[%0d] got %b exp 0", i, o_arb); else n_pass++;
      n_total++; if (o_adv !== 1'b1) $display("FAIL lost_adv[%0d] got %b exp 1", i, o_adv); else n_pass++;
      n_total++; if (o_run !== 3'd0) $display("FAIL lost_run[%0d] got %0d exp 0", i, o_run); else n_pass++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (o_tx !== 1'b1) $display("FAIL lost_end_tx got %b exp 1", o_tx); else n_pass++;
    n_total++; if (bus.state !== STUFF_NORMAL) $display("FAIL lost_end_state got %0d exp %0d", bus.state, STUFF_NORMAL); else n_pass++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (o_tx !== 1'b0) $display("FAIL after_lost_tx got %b exp 0", o_tx); else n_pass++;
    n_total++; if (o_run !== 3'd0) $display("FAIL after_lost_run got %0d exp 0", o_run); else n_pass++;
  endtask

  task automatic test_bit_error();
    logic [2:0] e_run [3];
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_total++; if (o_err !== 1'b1) $display("FAIL err_pulse got %b exp 1", o_err); else n_pass++;
    n_total++; if (o_arb !== 1'b0) $display("FAIL err_arb got %b exp 0", o_arb); else n_pass++;
    n_total++; if (o_run !== 3'd2) $display("FAIL err_run got %0d exp 2", o_run); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.bit_error !== 1'b0) $display("FAIL err_clear got %b exp 0", bus.bit_error); else n_pass++;
    e_run = '{3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++; if (o_run !== e_run[i]) $display("FAIL err_run2[%0d] got %0d exp %0d", i, o_run, e_run[i]); else n_pass++;
      n_total++; if (o_err !== 1'b0) $display("FAIL err_once[%0d] got %b exp 0", i, o_err); else n_pass++;
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (o_tx !== 1'b0) $display("FAIL err_stuff_tx got %b exp 0", o_tx); else n_pass++;
    n_total++; if (o_st !== 1'b1) $display("FAIL err_stuff_act got %b exp 1", o_st); else n_pass++;
    n_total++; if (o_adv !== 1'b0) $display("FAIL err_stuff_adv got %b exp 0", o_adv); else n_pass++;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (o_tx !== 1'b1) $display("FAIL err_post_tx got %b exp 1", o_tx); else n_pass++;
    n_total++; if (o_run !== 3'd1) $display("FAIL err_post_run got %0d exp 1", o_run); else n_pass++;
  endtask

  task automatic test_reset_pending();
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.state !== STUFF_INSERT) $display("FAIL pend_state got %0d exp %0d", bus.state, STUFF_INSERT); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.tx_bit_out !== 1'b1) $display("FAIL pend_rst_tx got %b exp 1", bus.tx_bit_out); else n_pass++;
    n_total++; if (bus.run_count !== 3'd0) $display("FAIL pend_rst_run got %0d exp 0", bus.run_count); else n_pass++;
    n_total++; if (bus.state !== STUFF_NORMAL) $display("FAIL pend_rst_state got %0d exp %0d", bus.state, STUFF_NORMAL); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (o_adv !== 1'b1) $display("FAIL pend_post_adv got %b exp 1", o_adv); else n_pass++;
    n_total++; if (o_st !== 1'b0) $display("FAIL pend_post_stuff got %b exp 0", o_st); else n_pass++;
    n_total++; if (o_tx !== 1'b1) $display("FAIL pend_post_tx got %b exp 1", o_tx); else n_pass++;
    n_total++; if (o_run !== 3'd1) $display("FAIL pend_post_run got %0d exp 1", o_run); else n_pass++;
  endtask

  initial begin
    n_total                = 0;
    n_pass                 = 0;
    rst_n                  = 1'b0;
    bus.sample_point       = 1'b0;
    bus.tx_bit_in          = 1'b1;
    bus.stuff_en           = 1'b0;
    bus.arbitration_active = 1'b0;
    bus.rx_bit             = 1'b1;
    test_reset();
    test_sof_id0();
    test_alternating();
    test_crc_end();
    test_arb_lost();
    test_bit_error();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
